// File: rtl/systolic_result_drain_if.sv
// Handshake bundle between the MAC array, the result drain and downstream consumers.
// The slave modport is the drain's view. The master modport is the surrounding logic's view.
interface systolic_result_drain_if #(
   parameter int unsigned N         = 2,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned ROW_W     = 1
);
   logic                       acc_valid;
   logic                       acc_ready;
   logic [N*N*ACC_WIDTH-1:0]   acc_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [N*OUT_WIDTH-1:0]     out_data;
   logic [ROW_W-1:0]           out_row;
   logic                       out_last;

   modport master (
      output acc_valid, acc_data, out_ready,
      input  acc_ready, out_valid, out_data, out_row, out_last
   );

   modport slave (
      input  acc_valid, acc_data, out_ready,
      output acc_ready, out_valid, out_data, out_row, out_last
   );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures a finished N x N accumulator matrix, then shifts and saturates it to OUT_WIDTH.
// The converted matrix streams out one row per valid/ready handshake.
module systolic_result_drain #(
   parameter int unsigned N         = 2,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned SHIFT     = 0,
   parameter int unsigned ROW_W     = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   systolic_result_drain_if.slave   bus,
   output logic                     busy,
   output logic                     overrun
);

   typedef enum logic {StIdle, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic                   overrun_q, overrun_d;
   logic [OUT_WIDTH-1:0]   buf_q [N][N];
   logic [OUT_WIDTH-1:0]   conv  [N][N];
   logic                   last_row;
   logic                   capture;

   // Saturation is detected when the bits above the output sign bit differ from the sign bit.
   function automatic logic [OUT_WIDTH-1:0] convert(input logic [ACC_WIDTH-1:0] acc);
      logic signed [ACC_WIDTH-1:0]    s;
      logic [ACC_WIDTH-OUT_WIDTH:0]   hi;
      s  = $signed(acc) >>> SHIFT;
      hi = s[ACC_WIDTH-1:OUT_WIDTH-1];
      if ((&hi) || !(|hi)) begin
         return s[OUT_WIDTH-1:0];
      end else if (s[ACC_WIDTH-1]) begin
         return {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         return {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            conv[i][j] = convert(bus.acc_data[ACC_WIDTH*(i*N+j) +: ACC_WIDTH]);
         end
      end
   end

   assign last_row      = (row_q == ROW_W'(N-1));
   assign bus.out_valid = (state_q == StDrain);
   assign bus.out_last  = bus.out_valid & last_row;
   assign bus.out_row   = row_q;
   assign bus.acc_ready = (state_q == StIdle) |
                          ((state_q == StDrain) & bus.out_last & bus.out_ready);
   assign capture       = bus.acc_valid & bus.acc_ready;
   assign busy          = (state_q == StDrain);
   assign overrun       = overrun_q;

   // Gate the buffer so out_data reads zero whenever no row is presented.
   always_comb begin
      bus.out_data = '0;
      if (state_q == StDrain) begin
         for (int j = 0; j < N; j++) begin
            bus.out_data[OUT_WIDTH*j +: OUT_WIDTH] = buf_q[row_q][j];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      overrun_d = overrun_q | (bus.acc_valid & ~bus.acc_ready);
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               state_d = StDrain;
               row_d   = '0;
            end
         end
         StDrain: begin
            if (bus.out_ready) begin
               if (!last_row) begin
                  row_d = row_q + ROW_W'(1);
               end else if (capture) begin
                  row_d = '0;
               end else begin
                  state_d = StIdle;
                  row_d   = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            row_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         row_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         buf_q <= conv;
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed checks of the result drain: conversion, backpressure, back-to-back capture,
// overrun and reset mid-drain. A second instance uses SHIFT=2.
module tb_systolic_result_drain;

   logic clk = 1'b0;
   logic reset;
   logic busy_a, overrun_a, busy_b, overrun_b;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   systolic_result_drain_if #(.N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .ROW_W(1)) bus_a ();
   systolic_result_drain_if #(.N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .ROW_W(1)) bus_b ();

   systolic_result_drain #(
      .N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0), .ROW_W(1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_a.slave),
      .busy    (busy_a),
      .overrun (overrun_a)
   );

   systolic_result_drain #(
      .N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(2), .ROW_W(1)
   ) dut_s2 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_b.slave),
      .busy    (busy_b),
      .overrun (overrun_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mat(input int c00, input int c01, input int c10,
                                        input int c11);
      return {32'(c11), 32'(c10), 32'(c01), 32'(c00)};
   endfunction

   function automatic logic [15:0] row(input int lane0, input int lane1);
      return {8'(lane1), 8'(lane0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_row(input string tag, input int r, input logic [15:0] d,
                            input logic last);
      check({tag, "_valid"}, bus_a.out_valid, 1'b1);
      check({tag, "_row"}, bus_a.out_row, r);
      check({tag, "_data"}, bus_a.out_data, d);
      check({tag, "_last"}, bus_a.out_last, last);
   endtask

   // Present one matrix for a single accepted cycle on instance A.
   task automatic load_a(input logic [127:0] m);
      bus_a.acc_data  = m;
      bus_a.acc_valid = 1'b1;
      tick();
      bus_a.acc_valid = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      bus_a.acc_valid = 1'b0;
      bus_a.acc_data  = '0;
      bus_a.out_ready = 1'b0;
      bus_b.acc_valid = 1'b0;
      bus_b.acc_data  = '0;
      bus_b.out_ready = 1'b1;
      tick();
      tick();

      check("rst_valid", bus_a.out_valid, 1'b0);
      check("rst_last", bus_a.out_last, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_overrun", overrun_a, 1'b0);
      check("rst_row", bus_a.out_row, 0);
      check("rst_data", bus_a.out_data, 0);
      reset = 1'b0;
      check("rst_acc_ready", bus_a.acc_ready, 1'b1);

      // Basic drain.
      bus_a.out_ready = 1'b1;
      load_a(mat(1, 2, 3, 4));
      check_row("basic_r0", 0, row(1, 2), 1'b0);
      check("basic_busy", busy_a, 1'b1);
      check("basic_r0_acc_ready", bus_a.acc_ready, 1'b0);
      tick();
      check_row("basic_r1", 1, row(3, 4), 1'b1);
      check("basic_r1_acc_ready", bus_a.acc_ready, 1'b1);
      tick();
      check("basic_done_valid", bus_a.out_valid, 1'b0);
      check("basic_done_ready", bus_a.acc_ready, 1'b1);
      check("basic_done_busy", busy_a, 1'b0);

      // Saturation on A and shift+saturation on B, in lockstep.
      bus_a.acc_data  = mat(300, -200, 127, -128);
      bus_b.acc_data  = mat(13, -13, 1024, -1);
      bus_a.acc_valid = 1'b1;
      bus_b.acc_valid = 1'b1;
      tick();
      bus_a.acc_valid = 1'b0;
      bus_b.acc_valid = 1'b0;
      check_row("sat_r0", 0, row(127, -128), 1'b0);
      check("shift_r0_data", bus_b.out_data, row(3, -4));
      check("shift_r0_row", bus_b.out_row, 0);
      tick();
      check_row("sat_r1", 1, row(127, -128), 1'b1);
      check("shift_r1_data", bus_b.out_data, row(127, -1));
      check("shift_r1_last", bus_b.out_last, 1'b1);
      tick();
      check("sat_done_valid", bus_a.out_valid, 1'b0);
      check("shift_done_valid", bus_b.out_valid, 1'b0);

      // Backpressure holds row0 stable.
      bus_a.out_ready = 1'b0;
      load_a(mat(9, 10, 11, 12));
      for (int k = 0; k < 3; k++) begin
         check_row("bp_hold", 0, row(9, 10), 1'b0);
         tick();
      end
      check_row("bp_hold_end", 0, row(9, 10), 1'b0);
      bus_a.out_ready = 1'b1;
      tick();
      check_row("bp_r1", 1, row(11, 12), 1'b1);
      tick();
      check("bp_done_valid", bus_a.out_valid, 1'b0);

      // Back-to-back capture during the last-row handshake.
      load_a(mat(21, 22, 23, 24));
      check_row("b2b_a_r0", 0, row(21, 22), 1'b0);
      tick();
      check_row("b2b_a_r1", 1, row(23, 24), 1'b1);
      bus_a.acc_data  = mat(5, 6, 7, 8);
      bus_a.acc_valid = 1'b1;
      check("b2b_acc_ready", bus_a.acc_ready, 1'b1);
      tick();
      bus_a.acc_valid = 1'b0;
      check_row("b2b_b_r0", 0, row(5, 6), 1'b0);
      check("b2b_overrun", overrun_a, 1'b0);
      tick();
      check_row("b2b_b_r1", 1, row(7, 8), 1'b1);
      tick();
      check("b2b_done_valid", bus_a.out_valid, 1'b0);
      check("b2b_done_overrun", overrun_a, 1'b0);

      // Overrun: matrix offered while row0 is stalled.
      bus_a.out_ready = 1'b0;
      load_a(mat(31, 32, 33, 34));
      bus_a.acc_data  = mat(99, 99, 99, 99);
      bus_a.acc_valid = 1'b1;
      check("ovr_acc_ready", bus_a.acc_ready, 1'b0);
      tick();
      bus_a.acc_valid = 1'b0;
      check("ovr_set", overrun_a, 1'b1);
      check_row("ovr_r0", 0, row(31, 32), 1'b0);
      bus_a.out_ready = 1'b1;
      tick();
      check_row("ovr_r1", 1, row(33, 34), 1'b1);
      tick();
      check("ovr_done_valid", bus_a.out_valid, 1'b0);
      check("ovr_sticky", overrun_a, 1'b1);

      // Reset while row0 is presented.
      load_a(mat(41, 42, 43, 44));
      check_row("rmd_r0", 0, row(41, 42), 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmd_valid", bus_a.out_valid, 1'b0);
      check("rmd_busy", busy_a, 1'b0);
      check("rmd_acc_ready", bus_a.acc_ready, 1'b1);
      check("rmd_overrun", overrun_a, 1'b0);
      check("rmd_data", bus_a.out_data, 0);
      load_a(mat(51, -52, 53, -54));
      check_row("rmd_new_r0", 0, row(51, -52), 1'b0);
      tick();
      check_row("rmd_new_r1", 1, row(53, -54), 1'b1);
      tick();
      check("rmd_new_done", bus_a.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
